// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and sizing helpers for the register-bank arbiter.
// FSM encoding plus address/index width derivation (both clamped to at least 1 bit).
package dff_bank_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int MIN_NUM_REQ = 2;
    localparam int MAX_NUM_REQ = 8;

    function automatic int aw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int iw_of(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_dff_reg.sv
// One bank word: DATA_W-bit register, synchronous active-low reset, load enable.
// Latency: q updates on the clock edge after en is sampled; no backpressure.
// Reset takes priority over a coincident load.
module dff_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing a DEPTH x DATA_W register bank among NUM_REQ requesters.
// Latency: ack 2 cycles after req is sampled in IDLE; one transaction per 3 cycles.
// Backpressure: losers hold req until their ack; DFF_BANK_ARB_LOCK_EN adds per-requester priority lock.
module dff_bank_arbiter
    import dff_bank_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
`ifdef DFF_BANK_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]                lock,
`endif
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                we,
    input  logic [NUM_REQ*aw_of(DEPTH)-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]         wdata,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                ack,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              busy,
    output logic [DEPTH*DATA_W-1:0]           bank_q
);

    localparam int AW = aw_of(DEPTH);
    localparam int IW = iw_of(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      gnt_idx;
    logic [IW-1:0]      next_idx;

    logic               sel_vld;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      cand;

    logic               g_we;
    logic               g_lock;
    logic [AW-1:0]      g_addr;
    logic [DATA_W-1:0]  g_wdata;

    logic [DEPTH-1:0]   word_en;
    logic [DATA_W-1:0]  word_q [DEPTH];
    logic [DATA_W-1:0]  rd_word;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (int'(rr_ptr) + k >= NUM_REQ) begin
                cand = IW'(int'(rr_ptr) + k - NUM_REQ);
            end else begin
                cand = IW'(int'(rr_ptr) + k);
            end
            if (req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        g_we    = 1'b0;
        g_lock  = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                g_we    = we[i];
                g_addr  = addr[i*AW +: AW];
                g_wdata = wdata[i*DATA_W +: DATA_W];
`ifdef DFF_BANK_ARB_LOCK_EN
                g_lock  = lock[i];
`endif
            end
        end
    end

    // Out-of-range addresses match no word: the write enables stay low and the read returns 0.
    always_comb begin
        word_en = '0;
        rd_word = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if (g_addr == AW'(w)) begin
                rd_word    = word_q[w];
                word_en[w] = (state == ACCESS) && g_we;
            end
        end
    end

    always_comb begin
        if (gnt_idx == IW'(NUM_REQ - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            gnt     <= '0;
            ack     <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gnt     <= ONE << sel_idx;
                        gnt_idx <= sel_idx;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!g_we) begin
                        rdata <= rd_word;
                    end
                    ack   <= gnt;
                    state <= DONE;
                end
                DONE: begin
                    ack    <= '0;
                    gnt    <= '0;
                    rr_ptr <= g_lock ? gnt_idx : next_idx;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    for (genvar w = 0; w < DEPTH; w++) begin : g_bank
        dff_reg #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (word_en[w]),
            .d       (g_wdata),
            .q       (word_q[w])
        );
        assign bank_q[w*DATA_W +: DATA_W] = word_q[w];
    end

endmodule
